// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: SCLK generation for all CPOL/CPHA modes, shift/sample
// strobes and go/busy/done transfer sequencing with abort.
module spi_sclk_engine #(
    parameter int DIV_W = 16,
    parameter int LEN_W = 7
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             go,
    input  logic             stop,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [DIV_W-1:0] divider,
    input  logic [LEN_W-1:0] char_len,
    output logic             sclk_out,
    output logic             shift_stb,
    output logic             sample_stb,
    output logic             last_stb,
    output logic             busy,
    output logic             done
);

    localparam int EW = LEN_W + 2;
    localparam logic [LEN_W:0] N_MAX = {1'b1, {LEN_W{1'b0}}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] hc_q, hc_d;
    logic [EW-1:0]    ec_q, ec_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [LEN_W:0]   nbits_q, nbits_d;

    logic sclk_q, sclk_d;
    logic shift_q, shift_d;
    logic sample_q, sample_d;
    logic last_q, last_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic          wrap;
    logic          final_edge;
    logic          leading;
    logic          last_sample;
    logic [EW-1:0] two_n;

    // Edge k = ec_q + 1; an even ec_q therefore marks a leading (odd) edge.
    always_comb begin
        two_n       = {nbits_q, 1'b0};
        wrap        = (hc_q == div_q);
        final_edge  = wrap && (ec_q == two_n - EW'(1));
        leading     = ~ec_q[0];
        last_sample = (ec_q >= two_n - EW'(2));
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (go) state_d = S_RUN;
            S_RUN:  if (stop || final_edge) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hc_d    = hc_q;
        ec_d    = ec_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        div_d   = div_q;
        nbits_d = nbits_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    div_d   = divider;
                    nbits_d = (char_len == '0) ? N_MAX : {1'b0, char_len};
                    hc_d    = '0;
                    ec_d    = '0;
                end
            end
            S_RUN: begin
                if (wrap) begin
                    hc_d = '0;
                    ec_d = ec_q + EW'(1);
                end else begin
                    hc_d = hc_q + DIV_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        sclk_d   = sclk_q;
        shift_d  = 1'b0;
        sample_d = 1'b0;
        last_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                sclk_d  = cpol;
                busy_d  = go;
                shift_d = go & ~cpha;
            end
            S_RUN: begin
                if (stop) begin
                    sclk_d = cpol_q;
                    busy_d = 1'b0;
                end else if (wrap) begin
                    sclk_d = final_edge ? cpol_q : ~sclk_q;
                    busy_d = ~final_edge;
                    done_d = final_edge;
                    if (cpha_q) begin
                        shift_d  = leading;
                        sample_d = ~leading;
                    end else begin
                        // The first bit was preloaded at go, so the final trailing edge has nothing to shift.
                        sample_d = leading;
                        shift_d  = ~leading & ~final_edge;
                    end
                    last_d = sample_d & last_sample;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            hc_q     <= '0;
            ec_q     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            nbits_q  <= '0;
            sclk_q   <= 1'b0;
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            hc_q     <= hc_d;
            ec_q     <= ec_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            div_q    <= div_d;
            nbits_q  <= nbits_d;
            sclk_q   <= sclk_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sclk_out   = sclk_q;
    assign shift_stb  = shift_q;
    assign sample_stb = sample_q;
    assign last_stb   = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed bench for spi_sclk_engine: per-cycle waveform capture compared against hand-derived bit vectors.
module tb_spi_sclk_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, go, stop, cpol, cpha;
    logic [15:0] divider;
    logic [6:0]  char_len;
    logic        sclk, shs, sas, las, bsy, dn;

    logic        go2;
    logic [7:0]  divider2;
    logic [2:0]  char_len2;
    logic        sclk2, shs2, sas2, las2, bsy2, dn2;

    int n_cmp = 0;
    int n_bad = 0;

    spi_sclk_engine #(.DIV_W(16), .LEN_W(7)) dut (
        .wb_clk(clk), .wb_rst(rst), .go(go), .stop(stop), .cpol(cpol), .cpha(cpha),
        .divider(divider), .char_len(char_len), .sclk_out(sclk), .shift_stb(shs),
        .sample_stb(sas), .last_stb(las), .busy(bsy), .done(dn)
    );

    spi_sclk_engine #(.DIV_W(8), .LEN_W(3)) dut2 (
        .wb_clk(clk), .wb_rst(rst), .go(go2), .stop(stop), .cpol(cpol), .cpha(cpha),
        .divider(divider2), .char_len(char_len2), .sclk_out(sclk2), .shift_stb(shs2),
        .sample_stb(sas2), .last_stb(las2), .busy(bsy2), .done(dn2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bit c of each vector holds the output value in cycle t0+c (go sampled at edge t0).
    // scen: 0 plain, 1 go held, 2 mid-transfer go/config changes, 3 stop after edge 3, 4 reset mid-run.
    task automatic capture(input int scen, input int ncyc,
                           output logic [31:0] vs, output logic [31:0] vsh, output logic [31:0] vsa,
                           output logic [31:0] vl, output logic [31:0] vb, output logic [31:0] vd);
        vs = '0; vsh = '0; vsa = '0; vl = '0; vb = '0; vd = '0;
        go = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (c == 1 && scen != 1) go = 1'b0;
            vs[c] = sclk; vsh[c] = shs; vsa[c] = sas; vl[c] = las; vb[c] = bsy; vd[c] = dn;
            if (scen == 2 && c == 3) begin
                go = 1'b1; divider = 16'd5; char_len = 7'd7; cpol = 1'b1; cpha = 1'b0;
            end
            if (scen == 2 && c == 4) go = 1'b0;
            if (scen == 2 && c == 9) begin
                cpol = 1'b0; cpha = 1'b1; divider = 16'd1; char_len = 7'd2;
            end
            if (scen == 3 && c == 7) stop = 1'b1;
            if (scen == 3 && c == 8) stop = 1'b0;
            if (scen == 4 && c == 4) rst = 1'b1;
            if (scen == 4 && c == 5) rst = 1'b0;
        end
    endtask

    task automatic drain;
        int n = 0;
        go = 1'b0; stop = 1'b0; rst = 1'b0;
        while (bsy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        if (bsy !== 1'b0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout busy=%b after %0d cycles, expected 0", bsy, n);
        end
        tick(); tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; go = 1'b0; stop = 1'b0; cpol = 1'b0; cpha = 1'b0;
        divider = '0; char_len = '0; go2 = 1'b0; divider2 = '0; char_len2 = '0;
        repeat (3) tick();
        n_cmp++;
        if ({sclk, shs, sas, las, bsy, dn, sclk2, bsy2, dn2} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got %b expected %b", {sclk, shs, sas, las, bsy, dn, sclk2, bsy2, dn2}, 9'b0);
        end
        rst = 1'b0; cpol = 1'b1;
        tick();
        n_cmp++;
        if (sclk !== 1'b1) begin n_bad++; $display("FAIL idle_cpol_track_hi got %b expected 1", sclk); end
        cpol = 1'b0;
        tick();
        n_cmp++;
        if (sclk !== 1'b0) begin n_bad++; $display("FAIL idle_cpol_track_lo got %b expected 0", sclk); end
    endtask

    task automatic test_mode0;
        logic [31:0] vs, vsh, vsa, vl, vb, vd;
        cpol = 1'b0; cpha = 1'b0; divider = 16'd1; char_len = 7'd2;
        tick();
        capture(0, 14, vs, vsh, vsa, vl, vb, vd);
        n_cmp++; if (vb  !== 32'h1FE) begin n_bad++; $display("FAIL mode0_busy got %h expected %h", vb, 32'h1FE); end
        n_cmp++; if (vs  !== 32'h198) begin n_bad++; $display("FAIL mode0_sclk got %h expected %h", vs, 32'h198); end
        n_cmp++; if (vsh !== 32'h022) begin n_bad++; $display("FAIL mode0_shift got %h expected %h", vsh, 32'h022); end
        n_cmp++; if (vsa !== 32'h088) begin n_bad++; $display("FAIL mode0_sample got %h expected %h", vsa, 32'h088); end
        n_cmp++; if (vl  !== 32'h080) begin n_bad++; $display("FAIL mode0_last got %h expected %h", vl, 32'h080); end
        n_cmp++; if (vd  !== 32'h200) begin n_bad++; $display("FAIL mode0_done got %h expected %h", vd, 32'h200); end
        drain();
    endtask

    task automatic test_mode3;
        logic [31:0] vs, vsh, vsa, vl, vb, vd;
        cpol = 1'b1; cpha = 1'b1; divider = 16'd0; char_len = 7'd8;
        tick(); tick();
        capture(0, 24, vs, vsh, vsa, vl, vb, vd);
        n_cmp++; if (vb  !== 32'h0001FFFE) begin n_bad++; $display("FAIL mode3_busy got %h expected %h", vb, 32'h0001FFFE); end
        n_cmp++; if (vs  !== 32'h01FEAAAA) begin n_bad++; $display("FAIL mode3_sclk got %h expected %h", vs, 32'h01FEAAAA); end
        n_cmp++; if (vsh !== 32'h00015554) begin n_bad++; $display("FAIL mode3_shift got %h expected %h", vsh, 32'h00015554); end
        n_cmp++; if (vsa !== 32'h0002AAA8) begin n_bad++; $display("FAIL mode3_sample got %h expected %h", vsa, 32'h0002AAA8); end
        n_cmp++; if (vl  !== 32'h00020000) begin n_bad++; $display("FAIL mode3_last got %h expected %h", vl, 32'h00020000); end
        n_cmp++; if (vd  !== 32'h00020000) begin n_bad++; $display("FAIL mode3_done got %h expected %h", vd, 32'h00020000); end
        n_cmp++; if ((vsh & vsa) !== 32'h0) begin n_bad++; $display("FAIL mode3_strobe_overlap got %h expected 0", vsh & vsa); end
        drain();
        cpol = 1'b0; cpha = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] vs, vsh, vsa, vl, vb, vd;
        cpol = 1'b0; cpha = 1'b0; divider = 16'd0; char_len = 7'd1;
        tick();
        capture(1, 12, vs, vsh, vsa, vl, vb, vd);
        n_cmp++; if (vb  !== 32'hDB6)  begin n_bad++; $display("FAIL b2b_busy got %h expected %h", vb, 32'hDB6); end
        n_cmp++; if (vd  !== 32'h1248) begin n_bad++; $display("FAIL b2b_done got %h expected %h", vd, 32'h1248); end
        n_cmp++; if (vsh !== 32'h492)  begin n_bad++; $display("FAIL b2b_shift got %h expected %h", vsh, 32'h492); end
        n_cmp++; if (vsa !== 32'h924)  begin n_bad++; $display("FAIL b2b_sample got %h expected %h", vsa, 32'h924); end
        n_cmp++; if (vl  !== 32'h924)  begin n_bad++; $display("FAIL b2b_last got %h expected %h", vl, 32'h924); end
        n_cmp++; if (vs  !== 32'h924)  begin n_bad++; $display("FAIL b2b_sclk got %h expected %h", vs, 32'h924); end
        drain();
    endtask

    task automatic test_mid_changes;
        logic [31:0] vs, vsh, vsa, vl, vb, vd;
        cpol = 1'b0; cpha = 1'b1; divider = 16'd1; char_len = 7'd2;
        tick();
        capture(2, 16, vs, vsh, vsa, vl, vb, vd);
        n_cmp++; if (vb  !== 32'h1FE) begin n_bad++; $display("FAIL midchg_busy got %h expected %h", vb, 32'h1FE); end
        n_cmp++; if (vs  !== 32'h198) begin n_bad++; $display("FAIL midchg_sclk got %h expected %h", vs, 32'h198); end
        n_cmp++; if (vsh !== 32'h088) begin n_bad++; $display("FAIL midchg_shift got %h expected %h", vsh, 32'h088); end
        n_cmp++; if (vsa !== 32'h220) begin n_bad++; $display("FAIL midchg_sample got %h expected %h", vsa, 32'h220); end
        n_cmp++; if (vl  !== 32'h200) begin n_bad++; $display("FAIL midchg_last got %h expected %h", vl, 32'h200); end
        n_cmp++; if (vd  !== 32'h200) begin n_bad++; $display("FAIL midchg_done got %h expected %h", vd, 32'h200); end
        drain();
    endtask

    task automatic test_abort;
        logic [31:0] vs, vsh, vsa, vl, vb, vd;
        cpol = 1'b0; cpha = 1'b1; divider = 16'd1; char_len = 7'd8;
        tick();
        capture(3, 30, vs, vsh, vsa, vl, vb, vd);
        n_cmp++; if (vb  !== 32'hFE) begin n_bad++; $display("FAIL abort_busy got %h expected %h", vb, 32'hFE); end
        n_cmp++; if (vs  !== 32'h98) begin n_bad++; $display("FAIL abort_sclk got %h expected %h", vs, 32'h98); end
        n_cmp++; if (vsh !== 32'h88) begin n_bad++; $display("FAIL abort_shift got %h expected %h", vsh, 32'h88); end
        n_cmp++; if (vsa !== 32'h20) begin n_bad++; $display("FAIL abort_sample got %h expected %h", vsa, 32'h20); end
        n_cmp++; if (vl  !== 32'h0)  begin n_bad++; $display("FAIL abort_last got %h expected 0", vl); end
        n_cmp++; if (vd  !== 32'h0)  begin n_bad++; $display("FAIL abort_done got %h expected 0", vd); end
        drain();
    endtask

    task automatic test_reset_run;
        logic [31:0] vs, vsh, vsa, vl, vb, vd;
        cpol = 1'b0; cpha = 1'b0; divider = 16'd1; char_len = 7'd2;
        go = 1'b1; rst = 1'b1;
        tick();
        go = 1'b0; rst = 1'b0;
        n_cmp++;
        if ({sclk, shs, sas, las, bsy, dn} !== 6'b0) begin
            n_bad++; $display("FAIL rst_with_go got %b expected %b", {sclk, shs, sas, las, bsy, dn}, 6'b0);
        end
        tick();
        n_cmp++;
        if (bsy !== 1'b0) begin n_bad++; $display("FAIL rst_with_go_busy got %b expected 0", bsy); end
        capture(4, 14, vs, vsh, vsa, vl, vb, vd);
        n_cmp++; if (vb  !== 32'h1E) begin n_bad++; $display("FAIL rstrun_busy got %h expected %h", vb, 32'h1E); end
        n_cmp++; if (vs  !== 32'h18) begin n_bad++; $display("FAIL rstrun_sclk got %h expected %h", vs, 32'h18); end
        n_cmp++; if (vsh !== 32'h02) begin n_bad++; $display("FAIL rstrun_shift got %h expected %h", vsh, 32'h02); end
        n_cmp++; if (vsa !== 32'h08) begin n_bad++; $display("FAIL rstrun_sample got %h expected %h", vsa, 32'h08); end
        n_cmp++; if (vd  !== 32'h0)  begin n_bad++; $display("FAIL rstrun_done got %h expected 0", vd); end
        drain();
    endtask

    task automatic test_wide_divider;
        int nb = 0, nsh = 0, nsa = 0, nl = 0, nd = 0, rise_c = 0, done_c = 0;
        logic prev;
        cpol = 1'b0; cpha = 1'b0; divider2 = 8'hFF; char_len2 = 3'd0;
        tick();
        prev = sclk2;
        go2 = 1'b1;
        for (int c = 1; c <= 4200; c++) begin
            tick();
            if (c == 1) go2 = 1'b0;
            nb += int'(bsy2); nsh += int'(shs2); nsa += int'(sas2); nl += int'(las2); nd += int'(dn2);
            if (sclk2 && !prev && rise_c == 0) rise_c = c;
            if (dn2 && done_c == 0) done_c = c;
            prev = sclk2;
        end
        n_cmp++; if (nb != 4096)     begin n_bad++; $display("FAIL wide_busy_cycles got %0d expected 4096", nb); end
        n_cmp++; if (nsh != 8)       begin n_bad++; $display("FAIL wide_shift_count got %0d expected 8", nsh); end
        n_cmp++; if (nsa != 8)       begin n_bad++; $display("FAIL wide_sample_count got %0d expected 8", nsa); end
        n_cmp++; if (nl != 1)        begin n_bad++; $display("FAIL wide_last_count got %0d expected 1", nl); end
        n_cmp++; if (nd != 1)        begin n_bad++; $display("FAIL wide_done_count got %0d expected 1", nd); end
        n_cmp++; if (rise_c != 257)  begin n_bad++; $display("FAIL wide_first_rise got %0d expected 257", rise_c); end
        n_cmp++; if (done_c != 4097) begin n_bad++; $display("FAIL wide_done_cycle got %0d expected 4097", done_c); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_mid_changes();
        test_abort();
        test_reset_run();
        test_wide_divider();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_sclk_engine.md
# spi_sclk_engine

Parametrised SPI serial-clock engine: successor to the single-mode SPI clock generator, supporting all four CPOL/CPHA modes, a generic divider width, and a programmable transfer length. It runs off the Wishbone clock and sits between the SPI control registers and the shift register. It produces the SCLK waveform and one-cycle shift/sample strobes, and it owns transfer sequencing through a go/busy/done handshake with abort.

## Interface
- DIV_W, 16: width of the divider; SCLK half-period = divider+1 wb_clk cycles.
- LEN_W, 7: width of char_len; max transfer 2^LEN_W bits.
- wb_clk  input  1  system clock; everything on its rising edge.
- wb_rst  input  1  reset; synchronous, active-high.
- go  input  1  start request; sampled only in IDLE.
- stop  input  1  abort request; sampled only in RUN.
- cpol  input  1  SCLK idle level.
- cpha  input  1  0: sample on leading edge; 1: sample on trailing edge.
- divider  input  DIV_W  half-period minus one.
- char_len  input  LEN_W  bits per transfer; 0 means 2^LEN_W.
- sclk_out  output  1  serial clock.
- shift_stb  output  1  one-cycle pulse: drive the next MOSI bit.
- sample_stb  output  1  one-cycle pulse: capture MISO.
- last_stb  output  1  coincides with the final sample_stb.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse on normal completion (not on abort).

## Operation
- Reset values: sclk_out=0, shift_stb=0, sample_stb=0, last_stb=0, busy=0, done=0. State is IDLE, and all counters and latched config are 0.
- wb_rst dominates go and stop. Reset during RUN returns the block to reset values at the next edge, with no done pulse.
- All outputs are registered.
- IDLE:
  - sclk_out <= cpol every cycle, so it tracks the live cpol with a one-cycle lag.
  - On go=1, latch cpol, cpha, divider and char_len. Set N = char_len, or 2^LEN_W when char_len is 0.
  - Clear the half-period counter hc and the edge counter ec (width LEN_W+2).
  - Set busy<=1 and enter RUN.
  - If the latched cpha=0, also assert shift_stb for one cycle (first-bit preload).
- RUN:
  - hc increments each cycle. The compare hc==divider uses the latched divider and wraps hc to 0; hc never exceeds divider.
  - divider=0 gives one cycle per half-period.
  - On each wrap, sclk_out toggles and ec increments. Edge number k=ec+1 is odd for a leading edge and even for a trailing edge.
  - CPHA=0: sample_stb on leading edges. shift_stb on trailing edges except the 2N-th.
  - CPHA=1: shift_stb on leading edges, sample_stb on trailing edges.
  - In every mode there are exactly N shift_stb and N sample_stb pulses per transfer. The two strobes are never high in the same cycle.
  - last_stb accompanies the N-th sample_stb.
  - On the 2N-th edge, sclk_out returns to the latched cpol, busy<=0, done<=1 and the state returns to IDLE.
- Abort: stop=1 in RUN forces IDLE at the next edge. sclk_out<=latched cpol, busy<=0, no strobes in that cycle, done stays 0.
- Ignored inputs:
  - go while busy is ignored.
  - stop in IDLE is ignored.
  - Changes to cpol, cpha, divider or char_len during RUN have no effect.
  - If stop and the 2N-th edge coincide, stop wins: no done pulse.

## Timing
- Let go be sampled at edge t0. At t0+1, busy=1 and the CPHA=0 preload shift_stb is visible.
- The k-th SCLK edge, with its strobe, is visible at t0+1+k*(divider+1).
- At t0+1+2N*(divider+1): busy=0, done=1 for one cycle, sclk_out=cpol.
- busy is high for exactly 2N*(divider+1) cycles.
- Back-to-back transfers: go asserted in the done cycle is accepted. busy rises again the next cycle, so there is a 1-cycle busy gap.
- Abort latency: stop at edge ts gives busy=0 at ts+1.

## Test plan
- Mode 0, divider=1, char_len=2, go at t0.
  - busy high cycles t0+1..t0+8. sclk_out rises at t0+3 and t0+7 and falls at t0+5 and t0+9.
  - shift_stb at t0+1 and t0+5.
  - sample_stb at t0+3 and t0+7, with last_stb at t0+7.
  - done at t0+9.
- Mode 3 (cpol=1, cpha=1), divider=0, char_len=8.
  - sclk idles high; 8 falling edges carry shift_stb and 8 rising edges carry sample_stb.
  - busy lasts 16 cycles; done asserts once; sclk ends high.
- char_len=0 with LEN_W=3 -> 8 bits, 16 edges, 8 sample_stb. divider=2^DIV_W-1 -> half-period 65536 cycles with no counter overflow.
- Boundary behaviour:
  - go held high continuously -> transfers repeat with a 1-cycle busy gap.
  - go pulsed mid-transfer -> ignored; pulse count unchanged.
  - divider changed mid-transfer -> period unchanged.
- stop after the 3rd edge of an 8-bit mode 1 transfer -> busy=0 the next cycle, sclk_out=0, done never asserts.
- wb_rst at the same edge as go, and wb_rst mid-RUN -> all outputs at reset values the following cycle, no done pulse.
